// File: rtl/stdu_pkg.sv
// stdu_pkg: shared constants and FSM states for the signal tone demap unit
package stdu_pkg;
    localparam int N_SC_DEF       = 480;
    localparam int BPS            = 2;
    localparam int FIFO_DEPTH_DEF = 4;
    typedef enum logic [1:0] {S_IDLE, S_B0, S_B1} state_e;
endpackage

// File: rtl/stdu_sym_fifo.sv
// stdu_sym_fifo: synchronous symbol FIFO with registered full/empty flags
module stdu_sym_fifo import stdu_pkg::*; #(
    parameter int W     = BPS,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full_q, full_d, empty_q, empty_d;

    assign rdata = mem_q[rp_q];
    assign full  = full_q;
    assign empty = empty_q;

    // pointer, occupancy and flag updates; clear discards all buffered symbols
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wp_q] = wdata;
                wp_d        = wp_q + AW'(1);
            end
            rp_d  = pop ? rp_q + AW'(1) : rp_q;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
        full_d  = cnt_d == CW'(DEPTH);
        empty_d = cnt_d == '0;
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q   <= '{default: '0};
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end
endmodule

// File: rtl/stdu.sv
// stdu: buffers QPSK symbols and serialises them d0-first, flagging each OFDM symbol's last bit
module stdu import stdu_pkg::*; #(
    parameter int N_SC       = N_SC_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic [BPS-1:0] di,
    input  logic           di_vld,
    output logic           di_rdy,
    output logic           do_bit,
    output logic           do_vld,
    output logic           do_last
);
    localparam int SC_W = $clog2(N_SC);
    state_e          st_q, st_d;
    logic [BPS-1:0]  sh_q, sh_d;
    logic [SC_W-1:0] sc_q, sc_d;
    logic            bit_q, bit_d, vld_q, vld_d, last_q, last_d;
    logic            push, pop, f_full, f_empty;
    logic [BPS-1:0]  f_rdata;

    assign di_rdy  = !f_full;
    assign push    = di_vld && di_rdy && !clr;
    assign do_bit  = bit_q;
    assign do_vld  = vld_q;
    assign do_last = last_q;

    stdu_sym_fifo #(.W(BPS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .wdata (di),
        .pop   (pop),
        .rdata (f_rdata),
        .full  (f_full),
        .empty (f_empty)
    );

    // serialiser: pop on IDLE/B1 so consecutive symbols emit without a bubble
    always_comb begin
        st_d   = st_q;
        sh_d   = sh_q;
        sc_d   = sc_q;
        bit_d  = bit_q;
        vld_d  = 1'b0;
        last_d = 1'b0;
        pop    = 1'b0;
        case (st_q)
            S_IDLE: begin
                pop  = !f_empty;
                sh_d = f_empty ? sh_q : f_rdata;
                st_d = f_empty ? S_IDLE : S_B0;
            end
            S_B0: begin
                bit_d = sh_q[0];
                vld_d = 1'b1;
                st_d  = S_B1;
            end
            S_B1: begin
                bit_d  = sh_q[1];
                vld_d  = 1'b1;
                last_d = sc_q == SC_W'(N_SC - 1);
                sc_d   = last_d ? '0 : sc_q + SC_W'(1);
                pop    = !f_empty;
                sh_d   = f_empty ? sh_q : f_rdata;
                st_d   = f_empty ? S_IDLE : S_B0;
            end
            default: st_d = S_IDLE;
        endcase
        if (clr) begin
            st_d   = S_IDLE;
            sh_d   = '0;
            sc_d   = '0;
            bit_d  = 1'b0;
            vld_d  = 1'b0;
            last_d = 1'b0;
            pop    = 1'b0;
        end
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            sh_q   <= '0;
            sc_q   <= '0;
            bit_q  <= 1'b0;
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            sh_q   <= sh_d;
            sc_q   <= sc_d;
            bit_q  <= bit_d;
            vld_q  <= vld_d;
            last_q <= last_d;
        end
    end
endmodule

// File: tb/tb_stdu.sv
// tb_stdu: directed checks of the signal tone demap unit
module tb_stdu;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [1:0] di = '0;
    logic       di_vld = 1'b0;
    logic       di_rdy, do_bit, do_vld, do_last;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rdy_low = 0;
    logic bits [$];
    logic lasts [$];
    int   vcyc [$];
    logic exp_bits [$];

    stdu dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .di      (di),
        .di_vld  (di_vld),
        .di_rdy  (di_rdy),
        .do_bit  (do_bit),
        .do_vld  (do_vld),
        .do_last (do_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // capture every valid output bit with its flag and cycle
    always @(negedge clk) begin
        if (rst_n && do_vld) begin
            bits.push_back(do_bit);
            lasts.push_back(do_last);
            vcyc.push_back(cyc);
        end
        if (rst_n && !di_rdy) rdy_low++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] s);
        int n = 0;
        @(negedge clk);
        di = s;
        di_vld = 1'b1;
        while (!di_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("rdy_timeout", 32'(n), 0);
        exp_bits.push_back(s[0]);
        exp_bits.push_back(s[1]);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        di_vld = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        bits.delete();
        lasts.delete();
        vcyc.delete();
        exp_bits.delete();
    endtask

    function automatic int bit_mism();
        int m = 0;
        if (bits.size() != exp_bits.size()) return -1;
        foreach (bits[i]) if (bits[i] !== exp_bits[i]) m++;
        return m;
    endfunction

    initial begin
        int   nl, li, m, gerr, miss;
        logic [15:0] pk;
        logic [1:0] s;

        // reset state
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_do", do_bit, 0);
        chk("rst_vld", do_vld, 0);
        chk("rst_last", do_last, 0);
        chk("rst_rdy", di_rdy, 1);

        // single symbol latency: d0 after edge t+2, d1 after edge t+3
        di = 2'b10;
        di_vld = 1'b1;
        @(posedge clk);
        #1 di_vld = 1'b0;
        @(negedge clk);
        chk("lat_t0_vld", do_vld, 0);
        @(negedge clk);
        chk("lat_t1_vld", do_vld, 0);
        @(negedge clk);
        chk("lat_t2_vld", do_vld, 1);
        chk("lat_t2_do", do_bit, 0);
        chk("lat_t2_last", do_last, 0);
        @(negedge clk);
        chk("lat_t3_vld", do_vld, 1);
        chk("lat_t3_do", do_bit, 1);
        @(negedge clk);
        chk("lat_t4_vld", do_vld, 0);
        chk("lat_hold_do", do_bit, 1);
        repeat (3) @(negedge clk);
        chk("lat_nbits", bits.size(), 2);

        // burst of 8 symbols with di_vld held
        clear_log();
        rdy_low = 0;
        for (int i = 0; i < 8; i++) send(2'(i % 4));
        idle(30);
        chk("burst_rdy_drop", rdy_low != 0, 1);
        chk("burst_nbits", bits.size(), 16);
        pk = '0;
        for (int i = 0; i < 16 && i < bits.size(); i++) pk[i] = bits[i];
        chk("burst_seq", pk, 16'hE4E4);
        chk("burst_contig", bits.size() == 16 ? vcyc[15] - vcyc[0] : -1, 15);

        // 481 symbols from a fresh frame: one do_last on bit 960
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 481; i++) send(2'($urandom_range(0, 3)));
        idle(20);
        nl = 0;
        li = -1;
        foreach (lasts[i]) if (lasts[i]) begin nl++; li = i; end
        chk("frame_nbits", bits.size(), 962);
        chk("frame_bits", bit_mism(), 0);
        chk("frame_nlast", nl, 1);
        chk("frame_last_idx", li, 959);
        chk("frame_sc_after", dut.sc_q, 1);

        // clr with symbols buffered mid-frame, di_vld in the same cycle
        for (int i = 0; i < 5; i++) send(2'b11);
        @(negedge clk);
        clr = 1'b1;
        di = 2'b11;
        di_vld = 1'b1;
        #1 clear_log();
        @(negedge clk);
        clr = 1'b0;
        di_vld = 1'b0;
        chk("clr_vld", do_vld, 0);
        chk("clr_rdy", di_rdy, 1);
        chk("clr_do", do_bit, 0);
        chk("clr_sc", dut.sc_q, 0);
        repeat (10) @(negedge clk);
        chk("clr_no_bits", bits.size(), 0);
        send(2'b01);
        idle(6);
        chk("clr_next_sc", dut.sc_q, 1);
        chk("clr_next_bits", bit_mism(), 0);

        // asynchronous reset mid-burst, away from any edge
        for (int i = 0; i < 3; i++) send(2'b11);
        #2;
        chk("arst_pre_vld", do_vld, 1);
        chk("arst_pre_do", do_bit, 1);
        di_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_do", do_bit, 0);
        chk("arst_vld", do_vld, 0);
        chk("arst_last", do_last, 0);
        chk("arst_rdy", di_rdy, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 10 OFDM symbols, one input symbol every 3rd cycle, tone-map round trip
        clear_log();
        miss = 0;
        for (int i = 0; i < 4800; i++) begin
            s = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (!di_rdy) miss++;
            di = s;
            di_vld = 1'b1;
            exp_bits.push_back(s[0]);
            exp_bits.push_back(s[1]);
            @(negedge clk);
            di_vld = 1'b0;
            @(negedge clk);
        end
        idle(10);
        chk("rt_rdy", miss, 0);
        chk("rt_nbits", bits.size(), 9600);
        chk("rt_bits", bit_mism(), 0);
        m = 0;
        foreach (lasts[i]) if (lasts[i] !== (i % 960 == 959)) m++;
        chk("rt_last", m, 0);
        gerr = 0;
        for (int k = 0; k + 1 < vcyc.size(); k += 2) begin
            if (vcyc[k + 1] - vcyc[k] != 1) gerr++;
            if (k + 2 < vcyc.size() && vcyc[k + 2] - vcyc[k] != 3) gerr++;
        end
        chk("rt_pattern", gerr, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
